line_buffer_bank: RTL and testbench

- Parametrised multi-line pixel buffer for the 2D FIR datapath.
- Stores the last NUM_LINES image lines in NUM_LINES simple-dual-port block RAMs.
- For every accepted input pixel, presents a vertical column of NUM_LINES+1 pixels: the current pixel plus the same column from each stored previous line. Also flags which taps hold valid data of the current frame.
- Sits between the pixel source and the FIR window/multiply-accumulate stage. Replaces single-bank, fixed-width line storage.

---
 rtl/line_buffer_bank_pkg.sv | 22 ++
 rtl/sdp_bram_rf.sv | 35 +++
 rtl/line_buffer_bank.sv | 155 +++++++++++++++
 tb/tb_line_buffer_bank.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buffer_bank_pkg.sv
// Shared constants and helpers for the multi-line pixel buffer.

`ifndef LBB_TAP_LO
`define LBB_TAP_LO(k, w) ((k) * (w))
`endif

package line_buffer_bank_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_LINE_LEN  = 2000;
  localparam int DEF_NUM_LINES = 4;
  localparam int DEF_ADDR_W    = 11;

  // Smallest r with 2^r >= value
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sdp_bram_rf.sv
// Simple-dual-port RAM: write port A, read port B with a registered,
// read-first output (a same-address write returns the previous contents).

module sdp_bram_rf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2000,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Port A write; array contents are never reset
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Port B registered read; holds its value while not enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/line_buffer_bank.sv
// Multi-line pixel buffer: for each accepted pixel, presents the current
// pixel plus the same column from the previous NUM_LINES lines, one cycle
// later. Banks rotate per line; the bank being written returns the oldest
// stored line thanks to the read-first RAM.

module line_buffer_bank
  import line_buffer_bank_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LINE_LEN  = DEF_LINE_LEN,
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ADDR_W-1:0]               line_len_i,
  input  logic                            in_valid,
  input  logic                            sof_i,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            out_valid,
  output logic [(NUM_LINES+1)*DATA_W-1:0] out_col,
  output logic [NUM_LINES:0]              out_tap_valid,
  output logic                            out_sof,
  output logic                            out_eol
);

  localparam int SEL_W  = (NUM_LINES > 1) ? clog2(NUM_LINES) : 1;
  localparam int ROWS_W = (NUM_LINES > 0) ? clog2(NUM_LINES + 1) : 1;
  // One extra bit so LINE_LEN == 2^ADDR_W is representable
  localparam int LEN_W  = ADDR_W + 1;

  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(LINE_LEN);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(NUM_LINES - 1);
  localparam logic [ROWS_W-1:0] ROWS_MAX = ROWS_W'(NUM_LINES);

  logic [ADDR_W-1:0] r_col;
  logic [SEL_W-1:0]  r_wr_sel;
  logic [ROWS_W-1:0] r_rows;
  logic [LEN_W-1:0]  r_len;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_tap0;
  logic [SEL_W-1:0]  r_rd_sel;
  logic [NUM_LINES:0] r_tap_valid;
  logic              r_out_sof;
  logic              r_out_eol;

  logic              w_sof;
  logic              w_eol;
  logic [ADDR_W-1:0] w_col;
  logic [SEL_W-1:0]  w_sel;
  logic [ROWS_W-1:0] w_rows;
  logic [LEN_W-1:0]  w_len;
  logic [LEN_W-1:0]  w_len_req;
  logic [NUM_LINES:0] w_tap_valid;
  logic [SEL_W-1:0]  w_bank;
  logic [(NUM_LINES+1)*DATA_W-1:0] w_out_col;
  logic [DATA_W-1:0] w_rd_data [NUM_LINES];

  // Effective per-pixel state: an accepted sof restarts the frame on this pixel
  always_comb begin
    w_sof     = in_valid & sof_i;
    w_len_req = {1'b0, line_len_i};
    if ((w_len_req == '0) || (w_len_req > LEN_MAX)) w_len_req = LEN_MAX;
    w_col  = w_sof ? '0 : r_col;
    w_sel  = w_sof ? '0 : r_wr_sel;
    w_rows = w_sof ? '0 : r_rows;
    w_len  = w_sof ? w_len_req : r_len;
    w_eol  = ({1'b0, w_col} == (w_len - LEN_W'(1)));
    w_tap_valid = '0;
    for (int k = 0; k <= NUM_LINES; k++) w_tap_valid[k] = (k <= int'(w_rows));
  end

  // Column / bank rotation / fill counters, advanced per accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col    <= '0;
      r_wr_sel <= '0;
      r_rows   <= '0;
      r_len    <= LEN_MAX;
    end else if (in_valid) begin
      r_len <= w_len;
      if (w_eol) begin
        r_col    <= '0;
        r_wr_sel <= (w_sel == SEL_LAST) ? '0 : w_sel + SEL_W'(1);
        r_rows   <= (w_rows == ROWS_MAX) ? w_rows : w_rows + ROWS_W'(1);
      end else begin
        r_col    <= w_col + ADDR_W'(1);
        r_wr_sel <= w_sel;
        r_rows   <= w_rows;
      end
    end
  end

  // Output-side registers aligned with the RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_tap0      <= '0;
      r_rd_sel    <= '0;
      r_tap_valid <= '0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_tap0      <= in_data;
        r_rd_sel    <= w_sel;
        r_tap_valid <= w_tap_valid;
        r_out_sof   <= w_sof;
        r_out_eol   <= w_eol;
      end else begin
        r_out_sof   <= 1'b0;
        r_out_eol   <= 1'b0;
      end
    end
  end

  for (genvar b = 0; b < NUM_LINES; b++) begin : g_bank
    logic w_we;
    assign w_we = in_valid && (w_sel == SEL_W'(b));
    sdp_bram_rf #(
      .DATA_W (DATA_W),
      .DEPTH  (LINE_LEN),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_we),
      .i_wr_addr (w_col),
      .i_wr_data (in_data),
      .i_rd_en   (in_valid),
      .i_rd_addr (w_col),
      .o_rd_data (w_rd_data[b])
    );
  end

  // Tap k comes from the bank written k lines ago
  always_comb begin
    w_out_col = '0;
    w_bank    = '0;
    w_out_col[`LBB_TAP_LO(0, DATA_W) +: DATA_W] = r_tap0;
    for (int k = 1; k <= NUM_LINES; k++) begin
      w_bank = SEL_W'((int'(r_rd_sel) + NUM_LINES - k) % NUM_LINES);
      w_out_col[`LBB_TAP_LO(k, DATA_W) +: DATA_W] = w_rd_data[w_bank];
    end
  end

  assign out_valid     = r_out_valid;
  assign out_col       = w_out_col;
  assign out_tap_valid = r_tap_valid;
  assign out_sof       = r_out_sof;
  assign out_eol       = r_out_eol;

endmodule

// File: tb/tb_line_buffer_bank.sv
// Bench for line_buffer_bank with a small geometry (8-bit, 8-deep, 2 lines).

module tb_line_buffer_bank;

  localparam int DW = 8;
  localparam int LL = 8;
  localparam int NL = 2;
  localparam int AW = 3;
  localparam int CW = (NL + 1) * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] line_len_i = '0;
  logic          in_valid = 1'b0;
  logic          sof_i = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [CW-1:0] out_col;
  logic [NL:0]   out_tap_valid;
  logic          out_sof;
  logic          out_eol;

  line_buffer_bank #(
    .DATA_W    (DW),
    .LINE_LEN  (LL),
    .NUM_LINES (NL),
    .ADDR_W    (AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .line_len_i    (line_len_i),
    .in_valid      (in_valid),
    .sof_i         (sof_i),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_col       (out_col),
    .out_tap_valid (out_tap_valid),
    .out_sof       (out_sof),
    .out_eol       (out_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] col;
    logic [NL:0]   tv;
    logic          sof;
    logic          eol;
    logic [DW-1:0] px;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model: frame image plus current position
  logic [DW-1:0] frame [32][LL];
  int m_col = 0;
  int m_row = 0;
  int m_len = LL;

  function automatic logic [CW-1:0] mask_of(input logic [NL:0] tv);
    logic [CW-1:0] m;
    m = '0;
    for (int k = 0; k <= NL; k++) if (tv[k]) m[k*DW +: DW] = '1;
    return m;
  endfunction

  // Drives one cycle; for a valid pixel the expected column is queued
  task automatic drive_px(input logic v, input logic s, input logic [AW-1:0] len,
                          input logic [DW-1:0] d);
    exp_t e;
    int lim;
    in_valid = v; sof_i = s; line_len_i = len; in_data = d;
    if (v) begin
      if (s) begin
        m_col = 0; m_row = 0;
        m_len = (len == 0 || int'(len) > LL) ? LL : int'(len);
      end
      frame[m_row % 32][m_col] = d;
      lim = (m_row < NL) ? m_row : NL;
      e.col = '0;
      e.col[DW-1:0] = d;
      e.px = d;
      for (int k = 0; k <= NL; k++) begin
        e.tv[k] = (k <= lim);
        if (k > 0 && k <= lim) e.col[k*DW +: DW] = frame[(m_row - k) % 32][m_col];
      end
      e.sof = s;
      e.eol = (m_col == m_len - 1);
      sb.push_back(e);
      if (e.eol) begin m_col = 0; m_row++; end
      else m_col++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; sof_i = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_col !== '0 || out_tap_valid !== '0 || out_sof !== 1'b0 || out_eol !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold got v=%b col=%h tv=%b sof=%b eol=%b want all zero", out_valid, out_col, out_tap_valid, out_sof, out_eol);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_px(1'b0, 1'b0, '0, '0);
      checks++;
      if (out_valid !== 1'b0 || out_col !== '0 || out_tap_valid !== '0 || out_sof !== 1'b0 || out_eol !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got v=%b col=%h tv=%b sof=%b eol=%b want all zero", i, out_valid, out_col, out_tap_valid, out_sof, out_eol);
      end
    end
  endtask

  task automatic test_stream;
    exp_t e;
    logic [CW-1:0] m;
    for (int p = 1; p <= 13; p++) begin
      drive_px(1'b1, (p == 1), 3'd4, DW'(p));
      e = sb.pop_front();
      m = mask_of(e.tv);
      checks++;
      if (out_valid !== 1'b1 || (out_col & m) !== e.col || out_tap_valid !== e.tv || out_sof !== e.sof || out_eol !== e.eol) begin
        failures++;
        $display("FAIL stream px=%0d got v=%b col=%h tv=%b sof=%b eol=%b want col=%h tv=%b sof=%b eol=%b",
                 e.px, out_valid, out_col & m, out_tap_valid, out_sof, out_eol, e.col, e.tv, e.sof, e.eol);
      end
      if (p == 1) begin
        checks++;
        if (out_sof !== 1'b1 || out_tap_valid !== 3'b001) begin
          failures++;
          $display("FAIL stream_first got sof=%b tv=%b want sof=1 tv=001", out_sof, out_tap_valid);
        end
      end
      if (p == 9) begin
        checks++;
        if (out_col !== 24'h010509 || out_tap_valid !== 3'b111) begin
          failures++;
          $display("FAIL stream_px9 got col=%h tv=%b want col=010509 tv=111", out_col, out_tap_valid);
        end
      end
      if (p == 13) begin
        checks++;
        if (out_col[23:16] !== 8'd5 || out_tap_valid !== 3'b111) begin
          failures++;
          $display("FAIL stream_wrap got tap2=%0d tv=%b want tap2=5 tv=111", out_col[23:16], out_tap_valid);
        end
      end
    end
  endtask

  task automatic test_gaps;
    exp_t e;
    exp_t last;
    logic [CW-1:0] m;
    int ng;
    last.col = '0; last.tv = '0; last.sof = 1'b0; last.eol = 1'b0; last.px = '0;
    for (int p = 21; p <= 32; p++) begin
      drive_px(1'b1, (p == 21), 3'd4, DW'(p));
      e = sb.pop_front();
      m = mask_of(e.tv);
      checks++;
      if (out_valid !== 1'b1 || (out_col & m) !== e.col || out_tap_valid !== e.tv || out_sof !== e.sof || out_eol !== e.eol) begin
        failures++;
        $display("FAIL gaps px=%0d got v=%b col=%h tv=%b sof=%b eol=%b want col=%h tv=%b sof=%b eol=%b",
                 e.px, out_valid, out_col & m, out_tap_valid, out_sof, out_eol, e.col, e.tv, e.sof, e.eol);
      end
      last = e;
      ng = $urandom_range(2, 1);
      for (int g = 0; g < ng; g++) begin
        drive_px(1'b0, 1'b1, 3'd2, 8'hEE);
        m = mask_of(last.tv);
        checks++;
        if (out_valid !== 1'b0 || (out_col & m) !== last.col || out_tap_valid !== last.tv || out_sof !== 1'b0 || out_eol !== 1'b0) begin
          failures++;
          $display("FAIL gap_hold after px=%0d got v=%b col=%h tv=%b sof=%b eol=%b want v=0 col=%h tv=%b sof=0 eol=0",
                   last.px, out_valid, out_col & m, out_tap_valid, out_sof, out_eol, last.col, last.tv);
        end
      end
    end
  endtask

  task automatic test_mid_sof;
    exp_t e;
    logic [CW-1:0] m;
    for (int p = 41; p <= 52; p++) begin
      drive_px(1'b1, (p == 41 || p == 43), (p == 43) ? 3'd0 : 3'd4, DW'(p));
      e = sb.pop_front();
      m = mask_of(e.tv);
      checks++;
      if (out_valid !== 1'b1 || (out_col & m) !== e.col || out_tap_valid !== e.tv || out_sof !== e.sof || out_eol !== e.eol) begin
        failures++;
        $display("FAIL mid_sof px=%0d got v=%b col=%h tv=%b sof=%b eol=%b want col=%h tv=%b sof=%b eol=%b",
                 e.px, out_valid, out_col & m, out_tap_valid, out_sof, out_eol, e.col, e.tv, e.sof, e.eol);
      end
      if (p == 43 || p == 46 || p == 50) begin
        checks++;
        if (out_sof !== (p == 43) || out_eol !== (p == 50) || (p == 43 && out_tap_valid !== 3'b001)) begin
          failures++;
          $display("FAIL mid_sof_len px=%0d got sof=%b eol=%b tv=%b", p, out_sof, out_eol, out_tap_valid);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    logic [CW-1:0] m;
    for (int p = 61; p <= 66; p++) begin
      drive_px(1'b1, (p == 61), 3'd4, DW'(p));
      void'(sb.pop_front());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_col !== '0 || out_tap_valid !== '0 || out_sof !== 1'b0 || out_eol !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got v=%b col=%h tv=%b sof=%b eol=%b want all zero", out_valid, out_col, out_tap_valid, out_sof, out_eol);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_col = 0; m_row = 0; m_len = LL;
    for (int p = 71; p <= 76; p++) begin
      drive_px(1'b1, (p == 71), 3'd4, DW'(p));
      e = sb.pop_front();
      m = mask_of(e.tv);
      checks++;
      if (out_valid !== 1'b1 || (out_col & m) !== e.col || out_tap_valid !== e.tv || out_sof !== e.sof || out_eol !== e.eol) begin
        failures++;
        $display("FAIL reset_restart px=%0d got v=%b col=%h tv=%b sof=%b eol=%b want col=%h tv=%b sof=%b eol=%b",
                 e.px, out_valid, out_col & m, out_tap_valid, out_sof, out_eol, e.col, e.tv, e.sof, e.eol);
      end
    end
  endtask

  task automatic test_no_sof;
    exp_t e;
    logic [CW-1:0] m;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_col = 0; m_row = 0; m_len = LL;
    for (int p = 81; p <= 90; p++) begin
      drive_px(1'b1, 1'b0, 3'd3, DW'(p));
      e = sb.pop_front();
      m = mask_of(e.tv);
      checks++;
      if (out_valid !== 1'b1 || (out_col & m) !== e.col || out_tap_valid !== e.tv || out_sof !== e.sof || out_eol !== e.eol) begin
        failures++;
        $display("FAIL no_sof px=%0d got v=%b col=%h tv=%b sof=%b eol=%b want col=%h tv=%b sof=%b eol=%b",
                 e.px, out_valid, out_col & m, out_tap_valid, out_sof, out_eol, e.col, e.tv, e.sof, e.eol);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_gaps();
    test_mid_sof();
    test_reset_mid();
    test_no_sof();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
